// File: rtl/enigma_uart_pkg.sv
// Shared constants, TX state encoding and the receive-byte letter filter for the UART/Enigma glue.
package enigma_uart_pkg;

  localparam logic [7:0] ASCII_A_UC  = 8'h41;
  localparam logic [7:0] ASCII_A_LC  = 8'h61;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  localparam int LETTER_W_DEF = 5;
  localparam int N_LETTERS    = 26;

  typedef enum logic [2:0] {
    T_IDLE,
    T_START,
    T_BUSY,
    T_DONE,
    T_SPACE
  } tx_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
  } rx_letter_t;

  // Upper and lower case fold onto the same 0..25 index; everything else is rejected.
  function automatic rx_letter_t map_rx_byte(input logic [7:0] b);
    rx_letter_t r;
    logic [7:0] off;
    r   = '0;
    off = '0;
    if (b >= ASCII_A_UC && b <= ASCII_A_UC + 8'(N_LETTERS - 1)) begin
      off     = b - ASCII_A_UC;
      r.valid = 1'b1;
    end else if (b >= ASCII_A_LC && b <= ASCII_A_LC + 8'(N_LETTERS - 1)) begin
      off     = b - ASCII_A_LC;
      r.valid = 1'b1;
    end
    r.idx = off[4:0];
    return r;
  endfunction

endpackage

// File: rtl/letter_fifo.sv
// Synchronous first-word fall-through FIFO; the head entry is always visible on o_data.
module letter_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_letter_bridge.sv
// UART <-> Enigma core glue: letter filter + FIFO on RX, index-to-ASCII paced TX FSM.
// Define GROUP5_EN to insert a space after every five transmitted letters.
module uart_letter_bridge
  import enigma_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LETTER_W   = LETTER_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_received,
  input  logic [7:0]          rx_byte,
  input  logic                rx_error,
  output logic [LETTER_W-1:0] letter_out,
  output logic                letter_valid,
  input  logic                letter_ready,
  input  logic [LETTER_W-1:0] enc_in,
  input  logic                enc_valid,
  output logic                enc_ready,
  output logic                uart_transmit,
  output logic [7:0]          uart_tx_byte,
  input  logic                uart_is_transmitting,
  output logic                overflow,
  output logic [7:0]          err_count
);

  rx_letter_t          w_rx;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [LETTER_W-1:0] w_head;
  logic [7:0]          w_enc_byte;

  logic                r_overflow;
  logic [7:0]          r_err_count;
  tx_state_t           r_state;
  logic                r_transmit;
  logic [7:0]          r_tx_byte;
  logic [1:0]          r_wait;
`ifdef GROUP5_EN
  logic [2:0]          r_group_cnt;
  logic                r_is_space;
`endif

  assign w_rx   = map_rx_byte(rx_byte);
  assign w_push = rx_received && w_rx.valid;
  assign w_pop  = letter_valid && letter_ready;

  letter_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LETTER_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (LETTER_W'(w_rx.idx)),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign letter_valid = !w_empty;
  assign letter_out   = w_empty ? '0 : w_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (rx_error && r_err_count != 8'hFF) r_err_count <= r_err_count + 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign err_count = r_err_count;

  assign w_enc_byte = (enc_in > LETTER_W'(N_LETTERS - 1)) ? ASCII_QMARK
                                                          : ASCII_A_UC + 8'(enc_in);

  // The strobe is registered: it is raised on the transition into T_START so it coincides with that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= T_IDLE;
      r_transmit  <= 1'b0;
      r_tx_byte   <= '0;
      r_wait      <= '0;
`ifdef GROUP5_EN
      r_group_cnt <= '0;
      r_is_space  <= 1'b0;
`endif
    end else begin
      r_transmit <= 1'b0;
      case (r_state)
        T_IDLE: begin
          if (enc_valid) begin
            r_tx_byte  <= w_enc_byte;
            r_transmit <= 1'b1;
            r_state    <= T_START;
          end
        end
        T_START: begin
          r_wait  <= '0;
          r_state <= T_BUSY;
        end
        T_BUSY: begin
          if (uart_is_transmitting) begin
            r_state <= T_DONE;
          end else if (r_wait == 2'd3) begin
            r_transmit <= 1'b1;
            r_state    <= T_START;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        T_DONE: begin
          if (!uart_is_transmitting) begin
`ifdef GROUP5_EN
            if (r_is_space) begin
              r_is_space <= 1'b0;
              r_state    <= T_IDLE;
            end else if (r_group_cnt == 3'd4) begin
              r_group_cnt <= '0;
              r_state     <= T_SPACE;
            end else begin
              r_group_cnt <= r_group_cnt + 1'b1;
              r_state     <= T_IDLE;
            end
`else
            r_state <= T_IDLE;
`endif
          end
        end
`ifdef GROUP5_EN
        T_SPACE: begin
          r_tx_byte  <= ASCII_SPACE;
          r_is_space <= 1'b1;
          r_transmit <= 1'b1;
          r_state    <= T_START;
        end
`endif
        default: r_state <= T_IDLE;
      endcase
    end
  end

  assign enc_ready     = (r_state == T_IDLE) && !rst;
  assign uart_transmit = r_transmit;
  assign uart_tx_byte  = r_tx_byte;

endmodule

// File: tb/tb_uart_letter_bridge.sv
// Directed self-checking bench for uart_letter_bridge with a small behavioural UART busy model.
module tb_uart_letter_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_received = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       rx_error = 1'b0;
  logic [4:0] letter_out;
  logic       letter_valid;
  logic       letter_ready = 1'b0;
  logic [4:0] enc_in = '0;
  logic       enc_valid = 1'b0;
  logic       enc_ready;
  logic       uart_transmit;
  logic [7:0] uart_tx_byte;
  logic       uart_is_transmitting = 1'b0;
  logic       overflow;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_pass   = 0;

  // UART model state
  int         cyc = 0;
  int         strobes = 0;
  int         last_strobe = 0;
  int         prev_strobe = 0;
  int         ignore_cnt = 0;
  int         busy_left = 0;
  int         stab_viol = 0;
  logic [7:0] cur_byte = '0;
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  uart_letter_bridge #(.FIFO_DEPTH(8), .LETTER_W(5)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rx_received          (rx_received),
    .rx_byte              (rx_byte),
    .rx_error             (rx_error),
    .letter_out           (letter_out),
    .letter_valid         (letter_valid),
    .letter_ready         (letter_ready),
    .enc_in               (enc_in),
    .enc_valid            (enc_valid),
    .enc_ready            (enc_ready),
    .uart_transmit        (uart_transmit),
    .uart_tx_byte         (uart_tx_byte),
    .uart_is_transmitting (uart_is_transmitting),
    .overflow             (overflow),
    .err_count            (err_count)
  );

  // Busy rises the cycle after an accepted strobe and stays high for 40 cycles.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      uart_is_transmitting <= 1'b0;
      busy_left = 0;
    end else begin
      if (uart_is_transmitting && uart_tx_byte != cur_byte) stab_viol++;
      if (uart_transmit) begin
        strobes++;
        prev_strobe = last_strobe;
        last_strobe = cyc;
        if (ignore_cnt > 0) begin
          ignore_cnt--;
        end else begin
          tx_q.push_back(uart_tx_byte);
          cur_byte = uart_tx_byte;
          busy_left = 40;
          uart_is_transmitting <= 1'b1;
        end
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) uart_is_transmitting <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_received = 1'b1;
    rx_byte     = b;
    tick();
    rx_received = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!enc_ready && n < 300) begin
      tick();
      n++;
    end
    if (!enc_ready) check("enc_ready_timeout", 32'(enc_ready), 32'd1);
  endtask

  task automatic send_enc(input logic [4:0] v);
    wait_ready();
    enc_valid = 1'b1;
    enc_in    = v;
    tick();
    enc_valid = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_drain [8];
    logic [7:0] exp_tx [$];
    int         s0;

    // Reset state
    tick();
    check("rst_enc_ready", 32'(enc_ready), 32'd0);
    check("rst_transmit", 32'(uart_transmit), 32'd0);
    check("rst_tx_byte", 32'(uart_tx_byte), 32'h00);
    do_reset();
    check("post_rst_valid", 32'(letter_valid), 32'd0);
    check("post_rst_letter", 32'(letter_out), 32'd0);
    check("post_rst_enc_ready", 32'(enc_ready), 32'd1);
    check("post_rst_overflow", 32'(overflow), 32'd0);
    check("post_rst_err", 32'(err_count), 32'd0);

    // 'H', 'i', '3' with the core always ready
    letter_ready = 1'b1;
    send_rx(8'h48);
    check("H_valid", 32'(letter_valid), 32'd1);
    check("H_index", 32'(letter_out), 32'd7);
    send_rx(8'h69);
    check("i_valid", 32'(letter_valid), 32'd1);
    check("i_index", 32'(letter_out), 32'd8);
    send_rx(8'h33);
    check("digit_dropped", 32'(letter_valid), 32'd0);
    check("digit_no_overflow", 32'(overflow), 32'd0);
    letter_ready = 1'b0;

    // Nine letters into an eight-entry FIFO
    for (int k = 0; k < 9; k++) send_rx(8'h41 + 8'(k));
    check("ovf_set", 32'(overflow), 32'd1);
    letter_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain_valid_%0d", k), 32'(letter_valid), 32'd1);
      check($sformatf("drain_idx_%0d", k), 32'(letter_out), 32'(k));
      tick();
    end
    check("drain_empty", 32'(letter_valid), 32'd0);
    letter_ready = 1'b0;

    // Push into a full FIFO while it pops is accepted
    do_reset();
    for (int k = 0; k < 8; k++) send_rx(8'h61 + 8'(k));
    check("full_no_ovf", 32'(overflow), 32'd0);
    rx_received  = 1'b1;
    rx_byte      = 8'h5A;
    letter_ready = 1'b1;
    tick();
    rx_received  = 1'b0;
    letter_ready = 1'b0;
    check("push_pop_full_no_ovf", 32'(overflow), 32'd0);
    exp_drain = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd25};
    letter_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("pp_drain_idx_%0d", k), 32'(letter_out), 32'(exp_drain[k]));
      tick();
    end
    check("pp_drain_empty", 32'(letter_valid), 32'd0);
    letter_ready = 1'b0;

    // Framing-error counter and saturation
    for (int k = 0; k < 3; k++) begin
      rx_error = 1'b1;
      tick();
      rx_error = 1'b0;
      tick();
    end
    check("err_3", 32'(err_count), 32'd3);
    rx_error = 1'b1;
    for (int k = 0; k < 260; k++) tick();
    rx_error = 1'b0;
    check("err_sat", 32'(err_count), 32'd255);

    // TX: 0, 25, 30
    tx_q.delete();
    s0 = strobes;
    send_enc(5'd0);
    check("tx_start_not_ready", 32'(enc_ready), 32'd0);
    for (int k = 0; k < 10; k++) tick();
    check("tx_busy_not_ready", 32'(enc_ready), 32'd0);
    send_enc(5'd25);
    send_enc(5'd30);
    wait_ready();
    check("tx_strobes", 32'(strobes - s0), 32'd3);
    check("tx_count", 32'(tx_q.size()), 32'd3);
    if (tx_q.size() == 3) begin
      check("tx_byte_A", 32'(tx_q[0]), 32'h41);
      check("tx_byte_Z", 32'(tx_q[1]), 32'h5A);
      check("tx_byte_q", 32'(tx_q[2]), 32'h3F);
    end

    // Ignored first strobe forces a re-strobe
    tx_q.delete();
    s0 = strobes;
    ignore_cnt = 1;
    send_enc(5'd2);
    wait_ready();
    check("restrobe_strobes", 32'(strobes - s0), 32'd2);
    check("restrobe_gap", 32'(last_strobe - prev_strobe), 32'd5);
    check("restrobe_count", 32'(tx_q.size()), 32'd1);
    if (tx_q.size() == 1) check("restrobe_byte", 32'(tx_q[0]), 32'h43);

    // Six letters: grouped output when GROUP5_EN is defined
    do_reset();
    tx_q.delete();
    for (int k = 0; k < 6; k++) send_enc(5'(k));
    wait_ready();
`ifdef GROUP5_EN
    exp_tx = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h20, 8'h46};
`else
    exp_tx = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
`endif
    check("group_count", 32'(tx_q.size()), 32'(exp_tx.size()));
    for (int k = 0; k < exp_tx.size() && k < tx_q.size(); k++)
      check($sformatf("group_byte_%0d", k), 32'(tx_q[k]), 32'(exp_tx[k]));

    // Reset while waiting in T_BUSY
    for (int k = 0; k < 9; k++) send_rx(8'h61);
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    ignore_cnt = 1;
    send_enc(5'd3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_transmit", 32'(uart_transmit), 32'd0);
    check("mid_rst_enc_ready", 32'(enc_ready), 32'd1);
    check("mid_rst_fifo_empty", 32'(letter_valid), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    s0 = strobes;
    for (int k = 0; k < 8; k++) tick();
    check("mid_rst_no_strobe", 32'(strobes - s0), 32'd0);
    check("tx_byte_stable", 32'(stab_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_letter_bridge.md
Name: uart_letter_bridge

Overview:
- Glue stage between the UART and the Enigma rotor core.
- Consumes the UART receive strobe and byte, keeps letters only (mapped to index 0..25), buffers them in a small FIFO and offers them to the core over a valid/ready handshake.
- Takes encrypted indices back from the core, converts them to uppercase ASCII and drives the UART transmit strobe, pacing on the UART busy flag.

Parameters:
- FIFO_DEPTH, 8, receive-side letter FIFO entries; power of 2, minimum 2.
- LETTER_W, 5, width of letter index bus.

Ports:
- clk  input  1  master clock, same domain as UART.
- rst  input  1  synchronous reset, active-high.
- rx_received  input  1  one-cycle pulse from UART: byte valid.
- rx_byte  input  8  received byte; valid when rx_received=1.
- rx_error  input  1  UART framing-error pulse; counted only.
- letter_out  output  LETTER_W  FIFO head index, 0..25.
- letter_valid  output  1  FIFO not empty.
- letter_ready  input  1  core accepts letter_out this cycle.
- enc_in  input  LETTER_W  encrypted index from core.
- enc_valid  input  1  enc_in valid.
- enc_ready  output  1  bridge can accept enc_in.
- uart_transmit  output  1  one-cycle transmit strobe to UART.
- uart_tx_byte  output  8  byte to UART; held stable from strobe until UART idle.
- uart_is_transmitting  input  1  UART busy flag.
- overflow  output  1  sticky: a letter was dropped because the FIFO was full.
- err_count  output  8  saturating count of rx_error pulses.

Behaviour:
- Reset: all outputs 0 (uart_tx_byte=0x00, enc_ready=0 during rst, overflow=0, err_count=0); FIFO emptied; TX FSM to T_IDLE. rst mid-transfer abandons the byte; no strobe is issued in the cycle after rst.
- RX filter on rx_received=1:
  - 0x41..0x5A maps to byte-0x41.
  - 0x61..0x7A maps to byte-0x61.
  - All other bytes are dropped silently.
- Push rules:
  - A letter is pushed if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise the letter is dropped and overflow is set until rst.
- Latency: rx_received at cycle N gives letter_valid=1 at N+1 when the FIFO was empty (first-word fall-through; letter_out driven from storage, not combinationally from rx_byte).
- Pop: when letter_valid and letter_ready. Simultaneous push and pop when empty: push only (nothing to pop). Pointers are LOG2(FIFO_DEPTH)+1 bits and wrap naturally.
- err_count increments on each rx_error pulse and saturates at 255.
- TX FSM:
  - T_IDLE: enc_ready=1. On enc_valid, capture and load uart_tx_byte = 0x41+enc_in, or 0x3F ('?') if enc_in>25. Go to T_START.
  - T_START: uart_transmit=1 for exactly one cycle. Go to T_BUSY.
  - T_BUSY: wait for uart_is_transmitting=1. If not seen within 4 cycles, return to T_START (re-strobe).
  - T_DONE: wait for uart_is_transmitting=0, then go to T_IDLE.
- enc_ready=0 in every state except T_IDLE, so at most one byte is in flight.
- RX and TX paths are independent; full-duplex operation is required.

Optional Feature:
- Macro: GROUP5_EN.
- Defined:
  - A 3-bit letter counter (reset 0) increments on each letter sent.
  - When the 5th letter finishes T_DONE, the counter clears and the FSM enters T_SPACE.
  - T_SPACE loads uart_tx_byte=0x20 and reuses the T_START/T_BUSY/T_DONE sequence; enc_ready stays 0 until the space completes.
  - Output is the classic five-letter groups.
- Undefined: no counter, no T_SPACE; output is letters only.

Decomposition:
- Package enigma_uart_pkg:
  - ASCII constants (0x41, 0x61, 0x20, 0x3F).
  - LETTER_W default and the letter-count constant 26.
  - TX state typedef (T_IDLE, T_START, T_BUSY, T_DONE, T_SPACE).
- Sub-module letter_fifo: synchronous first-word fall-through FIFO, parameterised by depth and width, exposing push/pop/full/empty.

Test Plan:
- rx bytes 'H'(0x48), 'i'(0x69), '3'(0x33) with letter_ready=1 -> letter_out 7 then 8; '3' dropped; overflow=0.
- 9 letters pushed with letter_ready=0, FIFO_DEPTH=8 -> 8 stored, overflow=1; then drain -> 8 indices in order and letter_valid=0 after the 8th pop.
- enc_in=0, 25, 30 with a UART model (busy 1 cycle after strobe, for 40 cycles) -> uart_tx_byte 0x41, 0x5A, 0x3F; one strobe each; enc_ready low between bytes.
- UART model ignores the first strobe -> re-strobe after 4 cycles; exactly one byte transmitted.
- With GROUP5_EN defined: 6 letters 'A'..'F' -> UART sees A B C D E 0x20 F.
- rst asserted in T_BUSY -> next cycle uart_transmit=0, enc_ready=1 (T_IDLE), FIFO empty, overflow=0.
